pattern_ctrl_regs: RTL and testbench
====================================

Name: pattern_ctrl_regs

Overview:
- Multi-channel Avalon-MM slave register file that supplies key-symbol patterns and write-enables to CHANNELS downstream pattern matchers.
- Patterns are written into shadow registers and moved into the active registers by a per-channel commit handshake, so a matcher never sees a half-updated pattern.
- Adds a registered read path (fixed latency 1), write backpressure on shadow words during a pending commit, and per-channel status with a match counter.

Parameters:
- REG_WIDTH, 32: Avalon data width and register width.
- PAT_WORDS, 3: pattern words per channel. PAT_SIZE = PAT_WORDS*REG_WIDTH.
- CHANNELS, 2: number of independent channels, 1..16.
- WORD_BITS, $clog2(PAT_WORDS+2): word-offset bits inside a channel.
- CH_BITS, (CHANNELS>1 ? $clog2(CHANNELS) : 1): channel-select bits.
- ADDR_WIDTH, CH_BITS+WORD_BITS: Avalon word address width.
- CNT_WIDTH, 16: match counter width, must be <= REG_WIDTH-16.

Ports:
- clk_i, input, 1: clock.
- arst_n_i, input, 1: reset, asynchronous assert, active-low.
- amm_slave_if, avalon_mm_if.slave, ADDR_WIDTH/REG_WIDTH: address, write, writedata, read (inputs); waitrequest, readdata, readdatavalid (outputs).
- pattern_o, output, [CHANNELS][0:PAT_SIZE-1]: active patterns. Word w occupies bits [w*REG_WIDTH : (w+1)*REG_WIDTH-1].
- wrken_o, output, [CHANNELS]: channel write-enable to the matcher.
- pattern_ready_i, input, [CHANNELS]: matcher idle; a new pattern may be loaded.
- match_i, input, [CHANNELS]: single-cycle pulse per detected match.

Behaviour:
- Address decode: address = {channel[CH_BITS-1:0], word[WORD_BITS-1:0]}.
  - Word 0: CTRL.
  - Word 1: STATUS, read-only.
  - Words 2..PAT_WORDS+1: shadow pattern words 0..PAT_WORDS-1.
- CTRL bits:
  - bit0 ENABLE: read/write.
  - bit1 COMMIT: write-1 pulse, reads 0.
  - bit2 CNT_CLR: write-1 pulse, reads 0.
  - Other bits reserved: read 0, writes ignored.
- STATUS bits:
  - bit0 COMMIT_PENDING (state != IDLE).
  - bit1 current wrken_o.
  - bits [16+CNT_WIDTH-1:16] match counter.
  - All other bits 0.
- Reset values:
  - Shadow and active pattern words: all ones.
  - ENABLE = 0; counters = 0; FSM = IDLE.
  - wrken_o = 0; readdata = 0; readdatavalid = 0.
- Read path:
  - waitrequest is never asserted for reads.
  - readdata and readdatavalid are registered: valid exactly 1 cycle after an accepted read.
  - Back-to-back reads are supported at 1 per cycle.
- Out-of-range address (channel >= CHANNELS or word > PAT_WORDS+1): read returns 0 with valid; write is accepted and discarded.
- Read and write in the same cycle: the write is performed, and the read returns the pre-write value.
- Write backpressure: waitrequest = write && (target is a shadow word) && (target channel FSM != IDLE). Writes to CTRL and STATUS are never stalled.
- Per-channel commit FSM, states IDLE, PENDING, COPY:
  - IDLE -> PENDING: on an accepted CTRL write with COMMIT=1.
  - PENDING -> COPY: at the edge where pattern_ready_i = 1.
  - COPY -> IDLE: active <= shadow (all words at the same edge).
  - COMMIT written while not IDLE: ignored.
  - An ENABLE write in any state is stored immediately.
- wrken_o[c] = ENABLE[c] && state[c] == IDLE, driven from registers only. It drops the cycle after a commit is accepted and returns the cycle after COPY.
- Match counter:
  - Increments on match_i and saturates at all ones.
  - CNT_CLR and match_i in the same cycle: the clear wins, result 0.
  - match_i is counted regardless of ENABLE.
- Reset asserted mid-commit: FSM returns to IDLE, shadow and active return to all ones, and the pending commit is lost.

Optional Feature:
- Macro: PATTERN_CTRL_MATCH_CNT_EN.
- Defined: match counters and CNT_CLR behave as above.
- Undefined:
  - No counter flops.
  - STATUS[31:16] reads 0.
  - match_i is ignored and CTRL bit2 has no effect.

Decomposition:
- Package pattern_ctrl_pkg holds:
  - Word offsets CTRL_OFS = 0, STATUS_OFS = 1, PAT_OFS = 2.
  - CTRL and STATUS bit positions.
  - typedef enum logic [1:0] commit_state_t {IDLE, PENDING, COPY}.
- Sub-module pattern_commit_fsm (one channel: FSM, wrken, counter), instantiated per channel by generate.
- The top level holds the decode, the read mux/register, and the shadow/active storage.

Test Plan:
- Reset, then read each channel's CTRL, STATUS and pattern words -> readdatavalid 1 cycle later. Values: CTRL = 0, STATUS = 0, pattern words 0xFFFFFFFF. wrken_o = 0.
- Write ch1 shadow words to 0x11111111/0x22222222/0x33333333, with CTRL = 0x1, then CTRL = 0x3 while pattern_ready_i[1] = 0 for 5 cycles:
  - wrken_o[1] = 0 and STATUS[0] = 1.
  - pattern_o[1] unchanged.
- Raise pattern_ready_i[1] -> 2 edges later pattern_o[1] = 0x111111112222222233333333, wrken_o[1] = 1, STATUS[0] = 0. Channel 0 is untouched throughout.
- While ch1 is PENDING, write its shadow word 0 -> waitrequest held high until COPY completes. Concurrent writes to ch0 shadow words complete without waitrequest.
- Pulse match_i[0] 3 times -> STATUS[16+:16] = 3. Then CTRL write 0x4 in the same cycle as a match pulse -> counter 0. Force 0xFFFF+1 pulses -> counter holds 0xFFFF (macro defined). Macro undefined -> always 0.
- Read at out-of-range address (word 7) -> readdata 0, valid after 1 cycle. Write there -> no register changes. Assert arst_n_i mid-PENDING -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/pattern_ctrl_pkg.sv
// pattern_ctrl_pkg: register map offsets, CTRL/STATUS bit positions and the commit FSM state type
package pattern_ctrl_pkg;
    localparam int CTRL_OFS           = 0;
    localparam int STATUS_OFS         = 1;
    localparam int PAT_OFS            = 2;
    localparam int CTRL_ENABLE_BIT    = 0;
    localparam int CTRL_COMMIT_BIT    = 1;
    localparam int CTRL_CNT_CLR_BIT   = 2;
    localparam int STATUS_PENDING_BIT = 0;
    localparam int STATUS_WRKEN_BIT   = 1;
    localparam int STATUS_CNT_LSB     = 16;

    typedef enum logic [1:0] {IDLE, PENDING, COPY} commit_state_t;
endpackage

// File: rtl/pattern_commit_fsm.sv
// pattern_commit_fsm: one channel's commit handshake, ENABLE/wrken register and match counter.
// The counter exists only when PATTERN_CTRL_MATCH_CNT_EN is defined.
module pattern_commit_fsm
    import pattern_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 arst_n_i,
    input  logic                 ctrl_wr_i,
    input  logic                 enable_i,
    input  logic                 commit_i,
    input  logic                 cnt_clr_i,
    input  logic                 pattern_ready_i,
    input  logic                 match_i,
    output logic                 enable_o,
    output logic                 pending_o,
    output logic                 copy_o,
    output logic                 wrken_o,
    output logic [CNT_WIDTH-1:0] cnt_o
);
    commit_state_t state_q, state_d;
    logic          enable_q, enable_d;
    logic          wrken_q, wrken_d;

    always_comb begin
        state_d  = state_q;
        enable_d = ctrl_wr_i ? enable_i : enable_q;
        case (state_q)
            IDLE:    state_d = (ctrl_wr_i && commit_i) ? PENDING : IDLE;
            PENDING: state_d = pattern_ready_i ? COPY : PENDING;
            default: state_d = IDLE;
        endcase
        // wrken is registered from next-state values so it never glitches
        wrken_d = enable_d && state_d == IDLE;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q  <= IDLE;
            enable_q <= 1'b0;
            wrken_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            enable_q <= enable_d;
            wrken_q  <= wrken_d;
        end
    end

    assign enable_o  = enable_q;
    assign pending_o = state_q != IDLE;
    assign copy_o    = state_q == COPY;
    assign wrken_o   = wrken_q;

`ifdef PATTERN_CTRL_MATCH_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (ctrl_wr_i && cnt_clr_i) ? '0 : (match_i && ~&cnt_q) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
`else
    logic unused_cnt_in;

    assign unused_cnt_in = match_i ^ cnt_clr_i;
    assign cnt_o         = '0;
`endif
endmodule

// File: rtl/pattern_ctrl_regs.sv
// pattern_ctrl_regs: Avalon-MM register file feeding shadow/active key patterns to CHANNELS matchers.
// Define PATTERN_CTRL_MATCH_CNT_EN to build the per-channel match counters.
module pattern_ctrl_regs
    import pattern_ctrl_pkg::*;
#(
    parameter int REG_WIDTH  = 32,
    parameter int PAT_WORDS  = 3,
    parameter int CHANNELS   = 2,
    parameter int CNT_WIDTH  = 16,
    parameter int PAT_SIZE   = PAT_WORDS * REG_WIDTH,
    parameter int WORD_BITS  = $clog2(PAT_WORDS + 2),
    parameter int CH_BITS    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    parameter int ADDR_WIDTH = CH_BITS + WORD_BITS
) (
    input  logic                              clk_i,
    input  logic                              arst_n_i,
    input  logic [ADDR_WIDTH-1:0]             amm_address_i,
    input  logic                              amm_write_i,
    input  logic [REG_WIDTH-1:0]              amm_writedata_i,
    input  logic                              amm_read_i,
    output logic                              amm_waitrequest_o,
    output logic [REG_WIDTH-1:0]              amm_readdata_o,
    output logic                              amm_readdatavalid_o,
    output logic [CHANNELS-1:0][0:PAT_SIZE-1] pattern_o,
    output logic [CHANNELS-1:0]               wrken_o,
    input  logic [CHANNELS-1:0]               pattern_ready_i,
    input  logic [CHANNELS-1:0]               match_i
);
    localparam int CH_SLOTS = 2 ** CH_BITS;

    logic [CH_BITS-1:0]                                ch;
    logic [WORD_BITS-1:0]                              word;
    logic                                              in_range, is_shadow, wr_acc;
    logic [CH_SLOTS-1:0]                               busy;
    logic [CHANNELS-1:0]                               enable, pending, copy;
    logic [CHANNELS-1:0][CNT_WIDTH-1:0]                cnt;
    logic [CHANNELS-1:0][PAT_WORDS-1:0][REG_WIDTH-1:0] shadow_q, shadow_d, active_q, active_d;
    logic [REG_WIDTH-1:0]                              rdata, rdata_q, rdata_d;
    logic                                              rvalid_q, rvalid_d;

    assign ch        = amm_address_i[ADDR_WIDTH-1 -: CH_BITS];
    assign word      = amm_address_i[WORD_BITS-1:0];
    assign in_range  = 32'(ch) < CHANNELS && 32'(word) <= PAT_WORDS + 1;
    assign is_shadow = in_range && 32'(word) >= PAT_OFS;
    // padded to every encodable channel so unused channel codes never stall
    assign busy      = CH_SLOTS'(pending);

    assign amm_waitrequest_o = amm_write_i && is_shadow && busy[ch];
    assign wr_acc            = amm_write_i && !amm_waitrequest_o && in_range;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic ctrl_wr;

        assign ctrl_wr = wr_acc && 32'(ch) == c && 32'(word) == CTRL_OFS;

        pattern_commit_fsm #(.CNT_WIDTH(CNT_WIDTH)) u_fsm (
            .clk_i           (clk_i),
            .arst_n_i        (arst_n_i),
            .ctrl_wr_i       (ctrl_wr),
            .enable_i        (amm_writedata_i[CTRL_ENABLE_BIT]),
            .commit_i        (amm_writedata_i[CTRL_COMMIT_BIT]),
            .cnt_clr_i       (amm_writedata_i[CTRL_CNT_CLR_BIT]),
            .pattern_ready_i (pattern_ready_i[c]),
            .match_i         (match_i[c]),
            .enable_o        (enable[c]),
            .pending_o       (pending[c]),
            .copy_o          (copy[c]),
            .wrken_o         (wrken_o[c]),
            .cnt_o           (cnt[c])
        );

        for (genvar w = 0; w < PAT_WORDS; w++) begin : g_w
            assign pattern_o[c][w*REG_WIDTH +: REG_WIDTH] = active_q[c][w];
        end
    end

    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int w = 0; w < PAT_WORDS; w++)
                if (wr_acc && 32'(ch) == c && 32'(word) == PAT_OFS + w)
                    shadow_d[c][w] = amm_writedata_i;
            if (copy[c])
                active_d[c] = shadow_q[c];
        end
    end

    // read mux works on current register values, so a same-cycle write is not visible yet
    always_comb begin
        rdata = '0;
        for (int c = 0; c < CHANNELS; c++)
            if (in_range && 32'(ch) == c) begin
                if (32'(word) == CTRL_OFS)
                    rdata = REG_WIDTH'(enable[c]);
                else if (32'(word) == STATUS_OFS)
                    rdata = REG_WIDTH'({cnt[c], {(STATUS_CNT_LSB-2){1'b0}}, wrken_o[c], pending[c]});
                else
                    for (int w = 0; w < PAT_WORDS; w++)
                        if (32'(word) == PAT_OFS + w)
                            rdata = shadow_q[c][w];
            end
        rdata_d  = amm_read_i ? rdata : '0;
        rvalid_d = amm_read_i;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            shadow_q <= '1;
            active_q <= '1;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign amm_readdata_o      = rdata_q;
    assign amm_readdatavalid_o = rvalid_q;
endmodule

// File: tb/tb_pattern_ctrl_regs.sv
// tb_pattern_ctrl_regs: directed bench; reads are scoreboarded against hand-computed values.
module tb_pattern_ctrl_regs;
`ifdef PATTERN_CTRL_MATCH_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif
    localparam logic [95:0] ONES = '1;
    localparam logic [95:0] PAT1 = 96'h111111112222222233333333;

    logic            clk = 1'b0;
    logic            arst_n = 1'b1;
    logic [3:0]      addr = '0;
    logic            write = 1'b0;
    logic            read = 1'b0;
    logic [31:0]     wdata = '0;
    logic            waitreq;
    logic [31:0]     rdata;
    logic            rvalid;
    logic [1:0][0:95] pattern;
    logic [1:0]      wrken;
    logic [1:0]      ready = '0;
    logic [1:0]      match = '0;
    int              checks = 0;
    int              failures = 0;
    int              cyc = 0;

    typedef struct {
        logic [31:0] d;
        int          c;
        string       n;
    } exp_t;
    exp_t q[$];
    exp_t e;

    pattern_ctrl_regs dut (
        .clk_i               (clk),
        .arst_n_i            (arst_n),
        .amm_address_i       (addr),
        .amm_write_i         (write),
        .amm_writedata_i     (wdata),
        .amm_read_i          (read),
        .amm_waitrequest_o   (waitreq),
        .amm_readdata_o      (rdata),
        .amm_readdatavalid_o (rvalid),
        .pattern_o           (pattern),
        .wrken_o             (wrken),
        .pattern_ready_i     (ready),
        .match_i             (match)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rvalid) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_rvalid: readdata=%h with nothing outstanding", rdata);
            end else begin
                e = q.pop_front();
                if (rdata !== e.d || cyc != e.c) begin
                    failures++;
                    $display("FAIL %s: readdata=%h at cycle %0d, expected %h at cycle %0d", e.n, rdata, cyc, e.d, e.c);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout: bench did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string n, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] d, input string n);
        @(negedge clk);
        read = 1'b1;
        write = 1'b0;
        addr = a;
        q.push_back('{d, cyc + 1, n});
    endtask

    task automatic rdwr(input logic [3:0] a, input logic [31:0] d, input logic [31:0] exp, input string n);
        @(negedge clk);
        read = 1'b1;
        write = 1'b1;
        addr = a;
        wdata = d;
        q.push_back('{exp, cyc + 1, n});
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, output int stalls);
        @(negedge clk);
        write = 1'b1;
        read = 1'b0;
        addr = a;
        wdata = d;
        stalls = 0;
        #1;
        while (waitreq && stalls < 100) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        if (waitreq) begin
            checks++;
            failures++;
            $display("FAIL write_timeout: addr=%h still stalled, expected acceptance", a);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            read = 1'b0;
            write = 1'b0;
        end
    endtask

    task automatic pulse0();
        @(negedge clk);
        read = 1'b0;
        write = 1'b0;
        match[0] = 1'b1;
        @(negedge clk);
        match[0] = 1'b0;
    endtask

    initial begin
        int st;
        #2 arst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_wrken", 96'(wrken), 96'(2'b00));
        chk("reset_rvalid", 96'(rvalid), 96'(1'b0));
        chk("reset_rdata", 96'(rdata), 96'(32'h0));
        chk("reset_pattern0", pattern[0], ONES);
        chk("reset_pattern1", pattern[1], ONES);
        arst_n = 1'b1;

        rd(4'h0, 32'h0, "ch0_ctrl_rst");
        rd(4'h1, 32'h0, "ch0_status_rst");
        rd(4'h2, 32'hFFFFFFFF, "ch0_w0_rst");
        rd(4'h3, 32'hFFFFFFFF, "ch0_w1_rst");
        rd(4'h4, 32'hFFFFFFFF, "ch0_w2_rst");
        rd(4'h8, 32'h0, "ch1_ctrl_rst");
        rd(4'h9, 32'h0, "ch1_status_rst");
        rd(4'hA, 32'hFFFFFFFF, "ch1_w0_rst");
        rd(4'hB, 32'hFFFFFFFF, "ch1_w1_rst");
        rd(4'hC, 32'hFFFFFFFF, "ch1_w2_rst");
        idle(2);

        rdwr(4'h0, 32'hFFFFFFF9, 32'h0, "rdwr_pre_value");
        rd(4'h0, 32'h1, "ch0_ctrl_reserved_ignored");

        wr(4'hA, 32'h11111111, st);
        wr(4'hB, 32'h22222222, st);
        wr(4'hC, 32'h33333333, st);
        wr(4'h8, 32'h1, st);
        idle(1);
        chk("wrken_enabled", 96'(wrken), 96'(2'b11));
        rd(4'hA, 32'h11111111, "ch1_shadow_w0");
        rd(4'hB, 32'h22222222, "ch1_shadow_w1");
        rd(4'hC, 32'h33333333, "ch1_shadow_w2");
        rd(4'h8, 32'h1, "ch1_ctrl_enable");
        idle(1);

        wr(4'h8, 32'h3, st);
        idle(5);
        chk("pending_wrken", 96'(wrken), 96'(2'b01));
        chk("pending_pattern1_unchanged", pattern[1], ONES);
        rd(4'h9, 32'h1, "ch1_status_pending");

        wr(4'h2, 32'hA5A5A5A5, st);
        chk("ch0_shadow_no_stall", 96'(st), 96'(0));
        fork
            wr(4'hA, 32'h44444444, st);
            begin
                repeat (3) @(negedge clk);
                ready[1] = 1'b1;
            end
        join
        chk("ch1_shadow_stall_cycles", 96'(st), 96'(4));
        idle(1);
        ready[1] = 1'b0;
        chk("commit_pattern1", pattern[1], PAT1);
        chk("commit_wrken", 96'(wrken), 96'(2'b11));
        chk("commit_pattern0_untouched", pattern[0], ONES);
        rd(4'h9, 32'h2, "ch1_status_idle");
        rd(4'hA, 32'h44444444, "ch1_shadow_after_stall");
        rd(4'h2, 32'hA5A5A5A5, "ch0_shadow_w0");
        rd(4'h1, 32'h2, "ch0_status_cnt0");

        repeat (3) pulse0();
        rd(4'h1, CNT_ON ? 32'h00030002 : 32'h00000002, "cnt_three");
        @(negedge clk);
        read = 1'b0;
        write = 1'b1;
        addr = 4'h0;
        wdata = 32'h5;
        match[0] = 1'b1;
        @(negedge clk);
        write = 1'b0;
        match[0] = 1'b0;
        rd(4'h1, 32'h00000002, "cnt_clear_wins");
        @(negedge clk);
        read = 1'b0;
        match[0] = 1'b1;
        repeat (CNT_ON ? 65536 : 20) @(negedge clk);
        match[0] = 1'b0;
        rd(4'h1, CNT_ON ? 32'hFFFF0002 : 32'h00000002, "cnt_saturate");

        rd(4'h7, 32'h0, "oor_ch0_word7");
        rd(4'h5, 32'h0, "oor_ch0_word5");
        rd(4'hD, 32'h0, "oor_ch1_word5");
        wr(4'h7, 32'hDEADBEEF, st);
        chk("oor_write_no_stall", 96'(st), 96'(0));
        wr(4'hD, 32'hDEADBEEF, st);
        wr(4'hF, 32'hDEADBEEF, st);
        idle(1);
        rd(4'h0, 32'h1, "oor_ch0_ctrl_kept");
        rd(4'h2, 32'hA5A5A5A5, "oor_ch0_w0_kept");
        rd(4'h3, 32'hFFFFFFFF, "oor_ch0_w1_kept");
        rd(4'h4, 32'hFFFFFFFF, "oor_ch0_w2_kept");
        rd(4'h8, 32'h1, "oor_ch1_ctrl_kept");
        rd(4'hB, 32'h22222222, "oor_ch1_w1_kept");
        idle(2);

        wr(4'h0, 32'h3, st);
        idle(2);
        rd(4'h1, CNT_ON ? 32'hFFFF0001 : 32'h00000001, "ch0_status_pending");
        idle(2);
        chk("ch0_pending_wrken", 96'(wrken), 96'(2'b10));
        #3 arst_n = 1'b0;
        #1;
        chk("async_rst_wrken", 96'(wrken), 96'(2'b00));
        chk("async_rst_pattern1", pattern[1], ONES);
        chk("async_rst_pattern0", pattern[0], ONES);
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        rd(4'h1, 32'h0, "post_rst_ch0_status");
        rd(4'h9, 32'h0, "post_rst_ch1_status");
        rd(4'hA, 32'hFFFFFFFF, "post_rst_ch1_w0");
        rd(4'h0, 32'h0, "post_rst_ch0_ctrl");
        idle(3);
        chk("scoreboard_drained", 96'(q.size()), 96'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
